// File: rtl/serial_subtractor_ctrl_pkg.sv
// rtl/serial_subtractor_ctrl_pkg.sv - shared state encodings and overflow helper for the serial subtractor
package serial_subtractor_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // Signed overflow of a - b: operands of opposite sign and result sign differs from a.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - single-bit full subtractor cell computing x - y - bin
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic bout,
  output logic d
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// rtl/serial_subtractor_ctrl.sv - bit-serial a - b, one bit per cycle LSB first, with IDLE/RUN/DONE control
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  import serial_subtractor_ctrl_pkg::*;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             a_msb, b_msb;
  logic             cell_d, cell_bout;

  full_subtractor u_cell (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (borrow),
    .bout (cell_bout),
    .d    (cell_d)
  );

  // Result fills from the MSB side so it is aligned after exactly WIDTH shifts.
  assign res_nxt = WIDTH'({cell_d, res_sh} >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (state == IDLE && start) begin
      a_sh   <= a;
      b_sh   <= b;
      res_sh <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      a_msb  <= a[WIDTH-1];
      b_msb  <= b[WIDTH-1];
    end else if (state == RUN) begin
      res_sh <= res_nxt;
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      borrow <= cell_bout;
      if (cnt != LAST) begin
        cnt <= cnt + 1'b1;
      end else begin
        diff <= res_nxt;
        bout <= cell_bout;
        ovf  <= sub_ovf(a_msb, b_msb, cell_d);
      end
    end
  end

endmodule
